// File: rtl/set_bit_serializer.sv
// rtl/set_bit_serializer.sv - serializes the set-bit indices of a vector, lowest first
module set_bit_serializer #(
  parameter int NUM_PORTS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_PORTS-1:0]         in_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_PORTS)-1:0] out_idx,
  output logic                         out_last,
  input  logic                         abort,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [0:0]           state;
  logic [NUM_PORTS-1:0] remaining;
  logic [NUM_PORTS-1:0] lowest;
  logic [NUM_PORTS-1:0] rest;
  logic [IDX_W-1:0]     lowest_idx;

  // Isolate the lowest set bit and the vector with that bit removed.
  always_comb begin
    lowest = remaining & (~remaining + ONE);
    rest   = remaining & (remaining - ONE);
  end

  // One-hot to binary encode of the isolated lowest bit.
  always_comb begin
    lowest_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (lowest[i]) begin
        lowest_idx = lowest_idx | IDX_W'(i);
      end
    end
  end

  // Handshake and index outputs; abort masks out_valid so no transfer can happen.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT) && !abort;
    out_idx   = lowest_idx;
    out_last  = (remaining != '0) && (rest == '0);
  end

  // FSM, remaining-bits register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            remaining <= in_vec;
            if (in_vec != '0) begin
              state <= EMIT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (abort) begin
            remaining <= '0;
            state     <= IDLE;
          end else if (out_ready) begin
            remaining <= rest;
            if (out_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_serializer.sv
// tb/tb_set_bit_serializer.sv - randomized self-checking bench for set_bit_serializer
module tb_set_bit_serializer;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         abort = 1'b0;
  logic         done;

  int errors = 0;
  int checks = 0;

  int q[$];
  bit done_pending = 1'b0;

  set_bit_serializer #(.NUM_PORTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .abort(abort), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare against the index-list model, then advance it.
  task automatic step(input logic iv, input logic [N-1:0] vec, input logic ordy, input logic ab);
    bit busy;
    bit exp_valid;
    @(negedge clk);
    in_valid = iv; in_vec = vec; out_ready = ordy; abort = ab;
    #1;
    busy = (q.size() != 0);
    exp_valid = busy && !ab;
    check("in_ready", in_ready, !busy);
    check("out_valid", out_valid, exp_valid);
    check("done", done, done_pending);
    if (exp_valid) begin
      check("out_idx", out_idx, q[0]);
      check("out_last", out_last, q.size() == 1);
    end
    done_pending = 1'b0;
    if (!busy) begin
      if (iv) begin
        for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
        if (q.size() == 0) done_pending = 1'b1;
      end
    end else if (ab) begin
      q.delete();
    end else if (ordy) begin
      void'(q.pop_front());
      if (q.size() == 0) done_pending = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    logic [N-1:0] v;
    int mode;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 8'b1010_0100 with out_ready held high
    step(1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // zero vector: done only
    step(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // all ones with out_ready toggling
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 8'h00, (i % 2) == 0, 1'b0);

    // abort on the cycle index 7 is presented, with out_ready high
    step(1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // abort in IDLE is ignored and the capture proceeds
    step(1'b1, 8'h06, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-vector after index 1
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    done_pending = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    step(1'b1, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0:       v = '0;
        1:       v = '1;
        2:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_bit_serializer.md
SET_BIT_SERIALIZER -- requirements
Module: set_bit_serializer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, the width of the request vector; legal values are 2 to 64.
REQ-002 SHALL have derived localparam IDX_W, value $clog2(NUM_PORTS), the width of a bit index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_vec holds a valid vector.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-007 SHALL have port in_vec, input, NUM_PORTS bits: the vector whose set bits are serialized.
REQ-008 SHALL have port out_valid, output, 1 bit: out_idx and out_last are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the current index.
REQ-010 SHALL have port out_idx, output, IDX_W bits: position of the lowest remaining set bit.
REQ-011 SHALL have port out_last, output, 1 bit: out_idx is the final set bit of the vector.
REQ-012 SHALL have port abort, input, 1 bit: synchronous discard of the vector in progress.
REQ-013 SHALL have port done, output, 1 bit: registered one-cycle pulse marking the end of a vector.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-015 SHALL drive in_ready = 1 in IDLE and in_ready = 0 in EMIT; no new vector is accepted while EMIT is active.
REQ-016 SHALL, in IDLE, capture in_vec into a remaining-bits register when in_valid && in_ready.
REQ-017 SHALL go IDLE -> EMIT on a capture with in_vec != 0; out_valid SHALL rise in the next cycle.
REQ-018 SHALL, on a capture with in_vec == 0, stay in IDLE and assert done for exactly one cycle in the next cycle, with no out_valid.
REQ-019 SHALL drive out_valid = (state == EMIT) && !abort.
REQ-020 SHALL drive out_idx as the index of the lowest set bit of the remaining register, via (x & -x) isolation followed by encoding.
REQ-021 SHALL drive out_last = 1 when the remaining register has exactly one bit set.
REQ-022 SHALL hold out_idx and out_last stable while out_valid && !out_ready.
REQ-023 SHALL, on each out_valid && out_ready, clear the emitted bit (x & (x-1)); throughput is one index per cycle.
REQ-024 SHALL, on a transfer with out_last = 1, go EMIT -> IDLE and pulse done in the next cycle.
REQ-025 SHALL let abort in EMIT clear the remaining register and return to IDLE with no done pulse.
REQ-026 SHALL give abort priority over a same-cycle output transfer; because out_valid is low, no transfer occurs.
REQ-027 SHALL ignore abort in IDLE, and a capture in that same cycle proceeds normally.
REQ-028 SHALL emit indices in strictly ascending order; the number of transfers per vector equals popcount(in_vec).
REQ-029 SHALL handle bit NUM_PORTS-1 and the all-ones vector, emitting NUM_PORTS indices with out_last only on index NUM_PORTS-1.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force state = IDLE, remaining register = 0 and done = 0.
REQ-031 SHALL, while rst_n = 0, present in_ready = 1, out_valid = 0, out_idx = 0 and out_last = 0.
REQ-032 SHALL, when reset is asserted mid-EMIT, drop the vector with no done pulse; first capture is possible on the first rising edge after rst_n rises.

Verification
REQ-033 SHALL pass: NUM_PORTS = 8, in_vec = 8'b1010_0100, out_ready = 1 -> out_idx 2, 5, 7 on consecutive cycles, out_last on 7, done one cycle later, in_ready back to 1.
REQ-034 SHALL pass: in_vec = 8'h00 -> no out_valid, done pulses once in the next cycle, state remains IDLE.
REQ-035 SHALL pass: in_vec = 8'hFF with out_ready toggling 1,0,1,0 -> indices 0..7 in order, each held stable through stalls, out_last only on 7.
REQ-036 SHALL pass: in_vec = 8'h81, abort asserted together with out_ready on the cycle index 7 is presented -> no transfer of 7, no done, IDLE next cycle.
REQ-037 SHALL pass: rst_n driven low asynchronously mid-EMIT with in_vec = 8'h0F after index 1 -> outputs immediately at reset values; after release, a new vector 8'h10 yields index 4 with out_last.
